// File: rtl/cmos_cap_pkg.sv
// Shared types and constants for the CMOS camera capture block.
package cmos_cap_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    SKIP      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  // Counters stick at all-ones instead of wrapping back to a plausible value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// Camera-side inputs and pixel-side outputs of cmos_capture, one bundle.
interface cmos_capture_if;
  logic        init_done;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;

  modport master (
    output init_done, cam_vsync, cam_href, cam_data,
    input  pix_data, pix_valid, frame_start, frame_done, line_err, frame_err
  );

  modport slave (
    input  init_done, cam_vsync, cam_href, cam_data,
    output pix_data, pix_valid, frame_start, frame_done, line_err, frame_err
  );
endinterface

// File: rtl/edge_det.sv
// Single-polarity edge detector: compares a signal with its one-cycle-delayed copy.
module edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_dly_d, sig_dly_q;

  always_comb sig_dly_d = sig;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_dly_q <= 1'b0;
    else     sig_dly_q <= sig_dly_d;
  end

  assign pulse = RISING ? (sig & ~sig_dly_q) : (~sig & sig_dly_q);

endmodule

// File: rtl/cmos_capture.sv
// Captures 8-bit camera bytes into RGB565 pixels, skipping start-up frames and flagging malformed lines/frames.
module cmos_capture
  import cmos_cap_pkg::*;
#(
  parameter int WAIT_FRAME = 10,
  parameter int H_PIXEL    = 1024,
  parameter int V_PIXEL    = 768
) (
  input  logic           cam_pclk,
  input  logic           rst,
  cmos_capture_if.slave  cam
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_FRAME);
  localparam logic [CNT_W-1:0] H_CNT    = CNT_W'(H_PIXEL);
  localparam logic [CNT_W-1:0] V_CNT    = CNT_W'(V_PIXEL);

  state_e           state_d, state_q;
  logic             vs_d, vs_q, href_d, href_q;
  logic [7:0]       data_d, data_q, byte0_d, byte0_q;
  logic [CNT_W-1:0] skip_cnt_d, skip_cnt_q, pix_cnt_d, pix_cnt_q, line_cnt_d, line_cnt_q;
  logic             tog_d, tog_q;
  logic [15:0]      pix_data_d, pix_data_q;
  logic             pix_valid_d, pix_valid_q, frame_start_d, frame_start_q;
  logic             frame_done_d, frame_done_q, line_err_d, line_err_q, frame_err_d, frame_err_q;
  logic             vs_rise, hs_fall;
  logic [CNT_W-1:0] skip_inc;
  logic             skip_done;

  edge_det #(.RISING(1'b1)) u_vs_edge (.clk(cam_pclk), .rst(rst), .sig(vs_q),   .pulse(vs_rise));
  edge_det #(.RISING(1'b0)) u_hs_edge (.clk(cam_pclk), .rst(rst), .sig(href_q), .pulse(hs_fall));

  assign skip_inc  = sat_inc(skip_cnt_q);
  // A zero skip count still enters ACTIVE on the first frame boundary.
  assign skip_done = (skip_inc >= WAIT_CNT);

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_INIT;
      vs_q          <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= '0;
      byte0_q       <= '0;
      skip_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      tog_q         <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      href_q        <= href_d;
      data_q        <= data_d;
      byte0_q       <= byte0_d;
      skip_cnt_q    <= skip_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      tog_q         <= tog_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!cam.init_done) begin
      state_d = WAIT_INIT;
    end else begin
      case (state_q)
        WAIT_INIT: state_d = SKIP;
        SKIP:      if (vs_rise && skip_done) state_d = ACTIVE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    vs_d          = cam.cam_vsync;
    href_d        = cam.cam_href;
    data_d        = cam.cam_data;
    byte0_d       = byte0_q;
    skip_cnt_d    = skip_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    tog_d         = tog_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = line_err_q;
    frame_err_d   = frame_err_q;

    if (!cam.init_done) begin
      tog_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_INIT: skip_cnt_d = '0;
        SKIP: begin
          if (vs_rise) begin
            skip_cnt_d = skip_inc;
            if (skip_done) begin
              frame_start_d = 1'b1;
              pix_cnt_d     = '0;
              line_cnt_d    = '0;
              tog_d         = 1'b0;
              line_err_d    = 1'b0;
              frame_err_d   = 1'b0;
            end
          end
        end
        ACTIVE: begin
          // Frame boundary wins over any same-cycle line end.
          if (vs_rise) begin
            frame_start_d = 1'b1;
            frame_err_d   = (line_cnt_q != V_CNT);
            pix_cnt_d     = '0;
            line_cnt_d    = '0;
            tog_d         = 1'b0;
            line_err_d    = 1'b0;
          end else if (href_q) begin
            tog_d = ~tog_q;
            if (!tog_q) begin
              byte0_d = data_q;
            end else begin
              pix_data_d  = {byte0_q, data_q};
              pix_valid_d = 1'b1;
              pix_cnt_d   = sat_inc(pix_cnt_q);
            end
          end else if (hs_fall) begin
            if (pix_cnt_q != H_CNT || tog_q) line_err_d = 1'b1;
            line_cnt_d   = sat_inc(line_cnt_q);
            pix_cnt_d    = '0;
            tog_d        = 1'b0;
            frame_done_d = (line_cnt_d == V_CNT) && (line_cnt_q != V_CNT);
          end
        end
        default: ;
      endcase
    end
  end

  assign cam.pix_data    = pix_data_q;
  assign cam.pix_valid   = pix_valid_q;
  assign cam.frame_start = frame_start_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.line_err    = line_err_q;
  assign cam.frame_err   = frame_err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture with WAIT_FRAME=2, H_PIXEL=4, V_PIXEL=2.
module tb_cmos_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmos_capture_if cif ();

  cmos_capture #(
    .WAIT_FRAME(2),
    .H_PIXEL   (4),
    .V_PIXEL   (2)
  ) dut (
    .cam_pclk(clk),
    .rst     (rst),
    .cam     (cif.slave)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          fs_cnt = 0;
  int          fd_cnt = 0;
  int          pv_cyc_q[$];
  logic [15:0] pv_dat_q[$];

  always @(negedge clk) begin
    if (cif.pix_valid === 1'b1) begin
      pv_cyc_q.push_back(cyc);
      pv_dat_q.push_back(cif.pix_data);
    end
    if (cif.frame_start === 1'b1) fs_cnt++;
    if (cif.frame_done === 1'b1) fd_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    cif.cam_vsync = 1'b1;
    repeat (2) step();
    cif.cam_vsync = 1'b0;
    repeat (4) step();
  endtask

  // Drives n bytes alternating b0/b1; with chk set, checks count, timing and value of each pixel.
  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1, input bit chk);
    int start = pv_cyc_q.size();
    int exp_cyc[$];
    int got;
    for (int i = 0; i < n; i++) begin
      cif.cam_href = 1'b1;
      cif.cam_data = i[0] ? b1 : b0;
      if (i[0]) exp_cyc.push_back(cyc + 2);
      step();
    end
    cif.cam_href = 1'b0;
    cif.cam_data = 8'h00;
    repeat (4) step();
    if (chk) begin
      got = pv_cyc_q.size() - start;
      checks++;
      if (got != exp_cyc.size()) begin
        errors++;
        $display("FAIL line_pixel_count: got %0d expected %0d", got, exp_cyc.size());
      end
      for (int i = 0; i < got && i < exp_cyc.size(); i++) begin
        checks++;
        if (pv_cyc_q[start+i] != exp_cyc[i]) begin
          errors++;
          $display("FAIL pix_latency[%0d]: got cycle %0d expected %0d", i, pv_cyc_q[start+i], exp_cyc[i]);
        end
        checks++;
        if (pv_dat_q[start+i] !== {b0, b1}) begin
          errors++;
          $display("FAIL pix_data[%0d]: got %h expected %h", i, pv_dat_q[start+i], {b0, b1});
        end
      end
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    checks++;
    if (cif.pix_data !== 16'h0000) begin
      errors++;
      $display("FAIL %s_pix_data: got %h expected 0000", tag, cif.pix_data);
    end
    chk_bit({tag, "_pix_valid"},   cif.pix_valid,   1'b0);
    chk_bit({tag, "_frame_start"}, cif.frame_start, 1'b0);
    chk_bit({tag, "_frame_done"},  cif.frame_done,  1'b0);
    chk_bit({tag, "_line_err"},    cif.line_err,    1'b0);
    chk_bit({tag, "_frame_err"},   cif.frame_err,   1'b0);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    cif.init_done = 1'b0;
    cif.cam_vsync = 1'b0;
    cif.cam_href  = 1'b0;
    cif.cam_data  = 8'h00;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
  endtask

  task automatic test_skip();
    int fs0, pv0;
    cif.init_done = 1'b1;
    step();
    pv0 = pv_cyc_q.size();
    fs0 = fs_cnt;
    send_line(8, 8'hF8, 8'h1F, 1'b0);
    vsync_pulse();
    chk_int("skip_fs_after_vs1", fs_cnt - fs0, 0);
    send_line(8, 8'hF8, 8'h1F, 1'b0);
    chk_int("skip_no_pix", pv_cyc_q.size() - pv0, 0);
    vsync_pulse();
    chk_int("skip_fs_after_vs2", fs_cnt - fs0, 1);
  endtask

  task automatic test_frame();
    int fs0 = fs_cnt;
    int fd0 = fd_cnt;
    send_line(8, 8'hF8, 8'h1F, 1'b1);
    chk_int("frame_done_after_line1", fd_cnt - fd0, 0);
    send_line(8, 8'hF8, 8'h1F, 1'b1);
    chk_int("frame_done_after_line2", fd_cnt - fd0, 1);
    chk_bit("frame_line_err", cif.line_err, 1'b0);
    vsync_pulse();
    chk_int("frame_fs_vs3", fs_cnt - fs0, 1);
    chk_bit("frame_frame_err", cif.frame_err, 1'b0);
  endtask

  task automatic test_odd_line();
    int fs0 = fs_cnt;
    int fd0 = fd_cnt;
    send_line(7, 8'hF8, 8'h1F, 1'b1);
    chk_bit("odd_line_err_set", cif.line_err, 1'b1);
    send_line(8, 8'hF8, 8'h1F, 1'b1);
    chk_bit("odd_line_err_sticky", cif.line_err, 1'b1);
    chk_int("odd_frame_done", fd_cnt - fd0, 1);
    vsync_pulse();
    chk_int("odd_fs_vs4", fs_cnt - fs0, 1);
    chk_bit("odd_line_err_cleared", cif.line_err, 1'b0);
    chk_bit("odd_frame_err", cif.frame_err, 1'b0);
  endtask

  task automatic test_frame_err();
    int fd0 = fd_cnt;
    send_line(8, 8'h12, 8'h34, 1'b1);
    checks++;
    if (cif.pix_data !== 16'h1234) begin
      errors++;
      $display("FAIL pix_data_hold: got %h expected 1234", cif.pix_data);
    end
    chk_int("short_frame_no_done", fd_cnt - fd0, 0);
    vsync_pulse();
    chk_bit("frame_err_set", cif.frame_err, 1'b1);
    send_line(8, 8'hA5, 8'h5A, 1'b1);
    send_line(8, 8'hA5, 8'h5A, 1'b1);
    chk_bit("frame_err_still_set", cif.frame_err, 1'b1);
    vsync_pulse();
    chk_bit("frame_err_cleared", cif.frame_err, 1'b0);
  endtask

  task automatic test_init_drop();
    int pv0 = pv_cyc_q.size();
    int fs0;
    cif.cam_href = 1'b1;
    cif.cam_data = 8'hF8;
    step();
    cif.cam_data  = 8'h1F;
    cif.init_done = 1'b0;
    step();
    cif.cam_data = 8'hF8;
    step();
    cif.cam_data = 8'h1F;
    step();
    cif.cam_href = 1'b0;
    cif.cam_data = 8'h00;
    repeat (4) step();
    chk_int("drop_no_pix", pv_cyc_q.size() - pv0, 0);
    cif.init_done = 1'b1;
    step();
    fs0 = fs_cnt;
    vsync_pulse();
    chk_int("drop_fs_vs1", fs_cnt - fs0, 0);
    send_line(8, 8'hF8, 8'h1F, 1'b0);
    chk_int("drop_skip_no_pix", pv_cyc_q.size() - pv0, 0);
    vsync_pulse();
    chk_int("drop_fs_vs2", fs_cnt - fs0, 1);
    send_line(8, 8'hF8, 8'h1F, 1'b1);
  endtask

  task automatic test_async_reset();
    send_line(7, 8'hF8, 8'h1F, 1'b0);
    chk_bit("pre_rst_line_err", cif.line_err, 1'b1);
    cif.cam_href = 1'b1;
    cif.cam_data = 8'hF8;
    step();
    cif.cam_data = 8'h1F;
    step();
    cif.cam_data = 8'hF8;
    step();
    chk_bit("pre_rst_pix_valid", cif.pix_valid, 1'b1);
    checks++;
    if (cif.pix_data !== 16'hF81F) begin
      errors++;
      $display("FAIL pre_rst_pix_data: got %h expected f81f", cif.pix_data);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    cif.cam_href = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_skip();
    test_frame();
    test_odd_line();
    test_frame_err();
    test_init_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 Parameter WAIT_FRAME, default 10: number of frames discarded after init_done rises.
REQ-002 Parameter H_PIXEL, default 1024: expected pixels per line.
REQ-003 Parameter V_PIXEL, default 768: expected lines per frame.
REQ-004 The module SHALL have these ports (name, direction, width, meaning):
- cam_pclk  in  1  sole clock, camera pixel clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- init_done  in  1  SDRAM and camera initialised (cam_pclk domain).
- cam_vsync  in  1  frame sync; rising edge marks a frame boundary.
- cam_href  in  1  line valid.
- cam_data  in  8  pixel byte.
- pix_data  out  16  RGB565 pixel {first byte, second byte}.
- pix_valid  out  1  pix_data valid for one cycle.
- frame_start  out  1  one-cycle pulse at each accepted frame boundary (drives SDRAM wr_load).
- frame_done  out  1  one-cycle pulse when line V_PIXEL of a frame completes.
- line_err  out  1  sticky: a line in the current frame had wrong length or odd byte count.
- frame_err  out  1  sticky: the previous frame had line count != V_PIXEL.

Function
REQ-005 cam_vsync, cam_href and cam_data SHALL be registered once on entry; all detection SHALL use the registered copies.
REQ-006 vsync rising edge (vs_rise) and href falling edge (hs_fall) SHALL be derived from the registered signals and one further delayed copy.
REQ-007 The FSM SHALL have states WAIT_INIT, SKIP, ACTIVE; reset state WAIT_INIT.
REQ-008 WAIT_INIT -> SKIP when init_done=1; skip counter cleared.
REQ-009 In SKIP, each vs_rise SHALL increment the skip counter; on the vs_rise that makes the count equal WAIT_FRAME, the state SHALL become ACTIVE and frame_start SHALL pulse in that same cycle.
REQ-010 WAIT_FRAME=0 SHALL pass through SKIP and enter ACTIVE on the first vs_rise.
REQ-011 From any state, init_done=0 SHALL force WAIT_INIT on the next edge; an in-flight pixel byte SHALL be dropped.
REQ-012 In ACTIVE, each vs_rise SHALL pulse frame_start, clear the line counter, pixel counter, byte toggle and line_err, and load frame_err with (line count != V_PIXEL).
REQ-013 While registered href=1 in ACTIVE, the byte toggle SHALL alternate; the first byte is latched, and the second byte completes the pixel.
REQ-014 pix_valid SHALL assert on the cycle after the edge that registers the second byte, i.e. 2 cycles after the second byte is present at cam_data; pix_data SHALL hold its value until the next pixel.
REQ-015 pix_valid SHALL never assert outside ACTIVE.
REQ-016 On hs_fall the pixel counter SHALL be compared to H_PIXEL; on mismatch or toggle=1 (odd byte), line_err SHALL set, and the dangling byte SHALL be discarded.
REQ-017 On hs_fall the line counter SHALL increment, then both the pixel counter and the toggle SHALL clear.
REQ-018 frame_done SHALL pulse once on the hs_fall that brings the line count to V_PIXEL.
REQ-019 The pixel counter (12 bits) and line counter (12 bits) SHALL saturate at all-ones, not wrap.
REQ-020 When vs_rise and hs_fall occur in the same cycle, vs_rise processing SHALL take priority and the line SHALL not be counted.

Reset
REQ-021 On rst: state=WAIT_INIT; pix_data=16'h0000; pix_valid, frame_start, frame_done, line_err and frame_err =0; all counters, the toggle and the input registers SHALL clear to 0.
REQ-022 Reset assertion SHALL be asynchronous; deassertion takes effect at the next cam_pclk edge.

Structure
REQ-023 Shared package cmos_cap_pkg SHALL hold the state enum and counter width constants (CNT_W=12).
REQ-024 One sub-module, edge_det (a registered rise/fall detector), SHALL be instantiated for vsync and for href.

Verification
REQ-025 init_done=1, WAIT_FRAME=2, 4 vsync pulses -> frame_start on 2nd, 3rd, 4th vs_rise only; no pix_valid before the 2nd.
REQ-026 H=4,V=2 frame, bytes 8'hF8,8'h1F repeated -> pix_valid 4 per line, pix_data=16'hF81F, 2 cycles after each second byte; frame_done once; no errors.
REQ-027 Line of 7 bytes -> 3 pixels, line_err=1 until next vs_rise, which clears it.
REQ-028 Frame of 1 line with V=2 -> frame_err=1 at next vs_rise; correct next frame -> frame_err=0 at the following vs_rise.
REQ-029 init_done dropped mid-line -> WAIT_INIT next cycle, pix_valid stays 0; reassert -> WAIT_FRAME frames are skipped again.
REQ-030 rst asserted mid-pixel -> all outputs 0 immediately, with no clock edge required.
